// File: rtl/ifu_fetch_if.sv
// Fetch unit bus: instruction-memory request/response plus the downstream
// instruction hand-off and redirect inputs.
interface ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: FETCH -> WAIT -> OUT, with
// redirect handling and discard of in-flight responses.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_OUT} state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic        r_discard;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [63:0] r_inst_pc;
    logic        r_inst_fault;

    logic        w_aligned;
    logic        w_req_fire;
    logic [63:0] w_pc_inc;

    assign w_aligned  = (r_pc[1:0] == 2'b00);
    assign w_req_fire = (r_state == S_FETCH) && w_aligned && bus.imem_req_ready;
    assign w_pc_inc   = r_pc + 64'd4;

    assign bus.imem_req_valid = (r_state == S_FETCH) && w_aligned;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = r_inst_valid;
    assign bus.inst           = r_inst;
    assign bus.inst_pc        = r_inst_pc;
    assign bus.inst_fault     = r_inst_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_discard    <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_inst_pc    <= 64'h0;
            r_inst_fault <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.redirect_valid) begin
                        r_pc <= bus.redirect_pc;
                        // A request accepted on the redirect edge is stale.
                        if (w_req_fire) begin
                            r_state   <= S_WAIT;
                            r_discard <= 1'b1;
                        end
                    end else if (w_aligned) begin
                        if (bus.imem_req_ready) begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_inst       <= 32'h0;
                        r_inst_pc    <= r_pc;
                        r_inst_fault <= 1'b1;
                        r_inst_valid <= 1'b1;
                        r_pc         <= w_pc_inc;
                        r_state      <= S_OUT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (bus.redirect_valid || r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= S_FETCH;
                            if (bus.redirect_valid) begin
                                r_pc <= bus.redirect_pc;
                            end
                        end else begin
                            r_inst       <= bus.imem_resp_err ? 32'h0 : bus.imem_resp_data;
                            r_inst_pc    <= r_pc;
                            r_inst_fault <= bus.imem_resp_err;
                            r_inst_valid <= 1'b1;
                            r_pc         <= w_pc_inc;
                            r_state      <= S_OUT;
                        end
                    end else if (bus.redirect_valid) begin
                        r_discard <= 1'b1;
                        r_pc      <= bus.redirect_pc;
                    end
                end
                S_OUT: begin
                    if (bus.redirect_valid) begin
                        r_pc         <= bus.redirect_pc;
                        r_inst_valid <= 1'b0;
                        r_state      <= S_FETCH;
                    end else if (bus.inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: table of fetch vectors plus hand-written redirect,
// misalignment, wrap and reset sequences, checked through a scoreboard queue.
module tb_ifu_fetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          stall;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [63:0] exp_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete request/response/hand-off; handoff=0 leaves the DUT in OUT.
    task automatic fetch_one(input logic [31:0] data, input logic err, input int stall,
                             input logic [31:0] exp_inst, input logic exp_fault,
                             input logic handoff);
        exp_t e;
        int   n;
        n = 0;
        while (bus.imem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("req_addr", bus.imem_req_addr, exp_pc);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        sb.push_back('{inst: exp_inst, pc: exp_pc, fault: exp_fault});
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        bus.imem_resp_err   = err;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_err   = 1'b0;
        chk("inst_valid", {63'h0, bus.inst_valid}, 64'h1);
        e = sb.pop_front();
        chk("inst", {32'h0, bus.inst}, {32'h0, e.inst});
        chk("inst_pc", bus.inst_pc, e.pc);
        chk("inst_fault", {63'h0, bus.inst_fault}, {63'h0, e.fault});
        $display("txn pc=%h inst=%h fault=%b stall=%0d", bus.inst_pc, bus.inst, bus.inst_fault, stall);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid", {63'h0, bus.inst_valid}, 64'h1);
            chk("stall_req", {63'h0, bus.imem_req_valid}, 64'h0);
            chk("stall_inst", {32'h0, bus.inst}, {32'h0, e.inst});
            chk("stall_pc", bus.inst_pc, e.pc);
            chk("stall_fault", {63'h0, bus.inst_fault}, {63'h0, e.fault});
        end
        exp_pc = exp_pc + 64'd4;
        if (handoff) begin
            bus.inst_ready = 1'b1;
            tick();
            bus.inst_ready = 1'b0;
            chk("handoff_valid", {63'h0, bus.inst_valid}, 64'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        exp_t e;
        vecs[0] = '{data: 32'h00100093, err: 1'b0, stall: 0, exp_inst: 32'h00100093, exp_fault: 1'b0};
        vecs[1] = '{data: 32'hDEADBEEF, err: 1'b0, stall: 5, exp_inst: 32'hDEADBEEF, exp_fault: 1'b0};
        vecs[2] = '{data: 32'h12345678, err: 1'b1, stall: 1, exp_inst: 32'h00000000, exp_fault: 1'b1};
        vecs[3] = '{data: 32'hFFFFFFFF, err: 1'b0, stall: 2, exp_inst: 32'hFFFFFFFF, exp_fault: 1'b0};

        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 64'h0;

        tick();
        tick();
        chk("rst_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("rst_inst", {32'h0, bus.inst}, 64'h0);
        chk("rst_inst_pc", bus.inst_pc, 64'h0);
        chk("rst_inst_fault", {63'h0, bus.inst_fault}, 64'h0);
        chk("rst_addr", bus.imem_req_addr, RESET_PC);
        rst = 1'b0;
        #1;
        chk("rel_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        exp_pc = RESET_PC;

        for (int i = 0; i < 4; i++) begin
            fetch_one(vecs[i].data, vecs[i].err, vecs[i].stall,
                      vecs[i].exp_inst, vecs[i].exp_fault, 1'b1);
        end

        // Redirect while waiting; the late response must be dropped.
        chk("pre_wait_addr", bus.imem_req_addr, exp_pc);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0000_0000_8000_0100;
        tick();
        bus.redirect_valid  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h0BADF00D;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("wredir_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("wredir_req", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("wredir_addr", bus.imem_req_addr, 64'h0000_0000_8000_0100);
        exp_pc = 64'h0000_0000_8000_0100;
        fetch_one(32'h00000013, 1'b0, 0, 32'h00000013, 1'b0, 1'b1);

        // Misaligned redirect produces a fault instruction without a request.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0000_0000_8000_0102;
        tick();
        bus.redirect_valid = 1'b0;
        chk("mis_req", {63'h0, bus.imem_req_valid}, 64'h0);
        sb.push_back('{inst: 32'h0, pc: 64'h0000_0000_8000_0102, fault: 1'b1});
        tick();
        chk("mis_valid", {63'h0, bus.inst_valid}, 64'h1);
        e = sb.pop_front();
        chk("mis_inst", {32'h0, bus.inst}, {32'h0, e.inst});
        chk("mis_pc", bus.inst_pc, e.pc);
        chk("mis_fault", {63'h0, bus.inst_fault}, {63'h0, e.fault});
        $display("txn pc=%h inst=%h fault=%b misaligned", bus.inst_pc, bus.inst, bus.inst_fault);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("mis_next_addr", bus.imem_req_addr, 64'h0000_0000_8000_0106);
        chk("mis_next_req", {63'h0, bus.imem_req_valid}, 64'h0);
        // Redirect in FETCH without handshake stays in FETCH.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0000_0000_8000_0200;
        tick();
        bus.redirect_valid = 1'b0;
        chk("fredir_req", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("fredir_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("fredir_addr", bus.imem_req_addr, 64'h0000_0000_8000_0200);
        exp_pc = 64'h0000_0000_8000_0200;

        // Redirect in OUT with same-cycle inst_ready.
        fetch_one(32'h11111111, 1'b0, 0, 32'h11111111, 1'b0, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0000_0000_8000_0300;
        bus.inst_ready     = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        chk("oredir_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("oredir_addr", bus.imem_req_addr, 64'h0000_0000_8000_0300);

        // Redirect coincident with request handshake: response is discarded.
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0000_0000_8000_0400;
        tick();
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h22222222;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("hredir_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("hredir_addr", bus.imem_req_addr, 64'h0000_0000_8000_0400);

        // Redirect in WAIT with same-cycle response.
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h33333333;
        bus.redirect_valid  = 1'b1;
        bus.redirect_pc     = 64'h0000_0000_8000_0500;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.redirect_valid  = 1'b0;
        chk("rwredir_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("rwredir_addr", bus.imem_req_addr, 64'h0000_0000_8000_0500);
        exp_pc = 64'h0000_0000_8000_0500;
        fetch_one(32'h44444444, 1'b0, 0, 32'h44444444, 1'b0, 1'b1);

        // pc wraps modulo 2^64 without faulting.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        fetch_one(32'h55555555, 1'b0, 0, 32'h55555555, 1'b0, 1'b1);
        fetch_one(32'h66666666, 1'b0, 0, 32'h66666666, 1'b0, 1'b1);

        // Asynchronous reset mid-WAIT, then a stale response.
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_addr", bus.imem_req_addr, RESET_PC);
        chk("arst_valid", {63'h0, bus.inst_valid}, 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_rel_req", {63'h0, bus.imem_req_valid}, 64'h1);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h77777777;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("stale_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("stale_req", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("stale_addr", bus.imem_req_addr, RESET_PC);
        exp_pc = RESET_PC;
        fetch_one(32'h00100093, 1'b0, 0, 32'h00100093, 1'b0, 1'b1);

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_req_addr  output  64  fetch address; always equals internal pc.
REQ-007 imem_resp_valid  input  1  response word valid, at most one per accepted request.
REQ-008 imem_resp_data  input  32  fetched instruction word.
REQ-009 imem_resp_err  input  1  access fault for this response.
REQ-010 inst_valid  output  1  instruction offered to downstream execute stage.
REQ-011 inst_ready  input  1  downstream accepts the offered instruction.
REQ-012 inst  output  32  instruction word.
REQ-013 inst_pc  output  64  address of inst.
REQ-014 inst_fault  output  1  inst carries a fetch fault (misaligned or access error).
REQ-015 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-016 redirect_pc  input  64  new fetch address.

Function
REQ-017 States FETCH, WAIT and OUT; at most one memory request is outstanding at any time.
REQ-018 FETCH: imem_req_valid=1 when pc[1:0]==0; on imem_req_ready the state moves to WAIT.
REQ-019 FETCH with pc[1:0]!=0: imem_req_valid=0; the next state is OUT with inst=0, inst_pc=pc, inst_fault=1, and pc+=4.
REQ-020 WAIT, imem_resp_valid with discard=0: latch inst=imem_resp_data (0 if imem_resp_err), inst_pc=pc, inst_fault=imem_resp_err, pc+=4, next state OUT.
REQ-021 WAIT, imem_resp_valid with discard=1: drop the response, clear discard, next state FETCH.
REQ-022 OUT: inst_valid=1 and inst/inst_pc/inst_fault are held stable until the inst_valid&inst_ready cycle, then the next state is FETCH.
REQ-023 Each instruction costs at least 3 cycles with a zero-latency memory: request, response, hand-off.
REQ-024 redirect_valid in any state: pc<=redirect_pc on that edge and takes priority over pc+=4.
REQ-025 Redirect in FETCH without handshake: stay in FETCH at the new pc.
REQ-026 Redirect in FETCH with handshake: go to WAIT with discard=1.
REQ-027 Redirect in WAIT without response: discard<=1.
REQ-028 Redirect in WAIT with same-cycle response: drop the response and go to FETCH.
REQ-029 Redirect in OUT: go to FETCH and drop inst_valid next cycle; a same-cycle inst_ready counts as a completed transfer.
REQ-030 pc arithmetic is 64-bit modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 with no fault.
REQ-031 imem_resp_valid outside WAIT is ignored.

Reset
REQ-032 While rst=1, outputs are forced immediately: pc=RESET_PC, state=FETCH, discard=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
REQ-033 When rst is released, the first imem_req_valid=1 with imem_req_addr=RESET_PC is driven in the same cycle.
REQ-034 rst asserted in WAIT: a later stale response is ignored per REQ-031, and fetching restarts at RESET_PC.

Verification
REQ-035 Scenario: after reset, memory returns 32'h00100093 one cycle after request -> inst_valid with inst=32'h00100093, inst_pc=64'h80000000; the next request is at 64'h80000004.
REQ-036 Scenario: inst_ready held 0 for 5 cycles in OUT -> inst, inst_pc and inst_fault are unchanged and no new request is issued.
REQ-037 Scenario: redirect to 64'h80000100 while in WAIT -> the pending response is dropped with no inst_valid, and the next request is at 64'h80000100.
REQ-038 Scenario: redirect to 64'h80000102 -> no memory request; inst_valid with inst_fault=1, inst=0, inst_pc=64'h80000102.
REQ-039 Scenario: imem_resp_err=1 -> inst_fault=1, inst=0, and the next request is at pc+4.
REQ-040 Scenario: rst pulsed mid-WAIT, then a stale imem_resp_valid arrives -> it is ignored and imem_req_addr=RESET_PC.
